ft_recovery_ctrl: RTL and testbench

Lockstep recovery controller for the dual-zeroriscy fault-tolerant SoC. It sits downstream of both cores' register-file write ports and upstream of their debug ports. It keeps a shadow copy of the architectural register file, updated only by writes on which both cores agree, plus a checkpoint PC. On a divergence it halts both cores, rewrites x1..x31 and the NPC of both cores through the debug interface, then resumes them.

---
 rtl/ft_recovery_ctrl.sv | 161 ++++++++++++++++
 tb/tb_ft_recovery_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ft_recovery_ctrl.sv
// rtl/ft_recovery_ctrl.sv - lockstep divergence recovery: shadow regfile, halt, rewrite, resume
module ft_recovery_ctrl #(
    parameter int unsigned HALT_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        we_a_i,
    input  logic        we_b_i,
    input  logic [4:0]  addr_a_i,
    input  logic [4:0]  addr_b_i,
    input  logic [31:0] data_a_i,
    input  logic [31:0] data_b_i,
    input  logic [31:0] pc_i,
    input  logic [1:0]  debug_halted_i,
    input  logic [1:0]  debug_gnt_i,
    output logic [1:0]  debug_req_o,
    output logic        debug_we_o,
    output logic [14:0] debug_addr_o,
    output logic [31:0] debug_wdata_o,
    output logic        debug_halt_o,
    output logic        debug_resume_o,
    output logic        busy_o,
    output logic        fatal_o,
    output logic [7:0]  recover_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_WAIT,
        S_WREG,
        S_WPC,
        S_RESUME,
        S_FAIL
    } state_e;

    state_e      state_q;
    logic [31:0] shadow_q [1:31];
    logic [31:0] pc_q;
    logic [4:0]  idx_q;
    logic [15:0] tmo_q;
    logic [1:0]  g_q;
    logic [1:0]  g_d;
    logic [7:0]  rcnt_q;
    logic        mismatch;
    logic        agree;
    logic        xfer;
    logic        word_done;

    assign mismatch = (we_a_i != we_b_i) |
                      (we_a_i & we_b_i & ((addr_a_i != addr_b_i) | (data_a_i != data_b_i)));
    assign agree    = we_a_i & we_b_i & ~mismatch & (addr_a_i != 5'd0);

    // Each core is requested until it grants; the word retires once both have granted.
    assign xfer        = (state_q == S_WREG) | (state_q == S_WPC);
    assign debug_req_o = {2{xfer}} & ~g_q;
    assign g_d         = g_q | (debug_req_o & debug_gnt_i);
    assign word_done   = xfer & (g_d == 2'b11);

    assign debug_we_o     = xfer;
    assign debug_halt_o   = (state_q == S_HALT);
    assign debug_resume_o = (state_q == S_RESUME);
    assign busy_o         = (state_q != S_IDLE);
    assign fatal_o        = (state_q == S_FAIL);
    assign recover_cnt_o  = rcnt_q;

    always_comb begin
        debug_addr_o  = 15'd0;
        debug_wdata_o = 32'd0;
        if (state_q == S_WREG) begin
            debug_addr_o  = 15'h400 + {8'd0, idx_q, 2'b00};
            debug_wdata_o = shadow_q[idx_q];
        end else if (state_q == S_WPC) begin
            debug_addr_o  = 15'h2000;
            debug_wdata_o = pc_q;
        end
    end

    // Shadow and checkpoint freeze while a recovery is in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q <= 32'd0;
            for (int i = 1; i < 32; i++) begin
                shadow_q[i] <= 32'd0;
            end
        end else if (state_q == S_IDLE) begin
            if (!mismatch) begin
                pc_q <= pc_i;
            end
            if (agree) begin
                shadow_q[addr_a_i] <= data_a_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            idx_q   <= 5'd0;
            tmo_q   <= 16'd0;
            g_q     <= 2'b00;
            rcnt_q  <= 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mismatch) begin
                        state_q <= S_HALT;
                    end
                end
                S_HALT: begin
                    tmo_q   <= 16'(HALT_TIMEOUT);
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (debug_halted_i == 2'b11) begin
                        idx_q   <= 5'd1;
                        state_q <= S_WREG;
                    end else begin
                        tmo_q <= tmo_q - 16'd1;
                        if (tmo_q == 16'd1) begin
                            state_q <= S_FAIL;
                        end
                    end
                end
                S_WREG: begin
                    if (word_done) begin
                        g_q <= 2'b00;
                        if (idx_q == 5'd31) begin
                            state_q <= S_WPC;
                        end else begin
                            idx_q <= idx_q + 5'd1;
                        end
                    end else begin
                        g_q <= g_d;
                    end
                end
                S_WPC: begin
                    if (word_done) begin
                        g_q     <= 2'b00;
                        state_q <= S_RESUME;
                    end else begin
                        g_q <= g_d;
                    end
                end
                S_RESUME: begin
                    if (rcnt_q != 8'hFF) begin
                        rcnt_q <= rcnt_q + 8'd1;
                    end
                    state_q <= S_IDLE;
                end
                S_FAIL: begin
                    state_q <= S_FAIL;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ft_recovery_ctrl.sv
// tb/tb_ft_recovery_ctrl.sv - directed self-checking bench for ft_recovery_ctrl
module tb_ft_recovery_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we_a, we_b;
    logic [4:0]  addr_a, addr_b;
    logic [31:0] data_a, data_b, pc;
    logic [1:0]  halted, gnt;
    logic [1:0]  dbg_req;
    logic        dbg_we;
    logic [14:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_halt, dbg_resume, busy, fatal;
    logic [7:0]  rcnt;

    logic [31:0] exp_sh [0:31];
    logic [31:0] exp_pc;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ft_recovery_ctrl #(.HALT_TIMEOUT(4)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .we_a_i         (we_a),
        .we_b_i         (we_b),
        .addr_a_i       (addr_a),
        .addr_b_i       (addr_b),
        .data_a_i       (data_a),
        .data_b_i       (data_b),
        .pc_i           (pc),
        .debug_halted_i (halted),
        .debug_gnt_i    (gnt),
        .debug_req_o    (dbg_req),
        .debug_we_o     (dbg_we),
        .debug_addr_o   (dbg_addr),
        .debug_wdata_o  (dbg_wdata),
        .debug_halt_o   (dbg_halt),
        .debug_resume_o (dbg_resume),
        .busy_o         (busy),
        .fatal_o        (fatal),
        .recover_cnt_o  (rcnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wa, input logic wb, input logic [4:0] aa, input logic [4:0] ab,
                         input logic [31:0] da, input logic [31:0] db);
        we_a = wa; we_b = wb; addr_a = aa; addr_b = ab; data_a = da; data_b = db;
        step();
        we_a = 1'b0; we_b = 1'b0;
    endtask

    task automatic write_agree(input logic [4:0] a, input logic [31:0] d);
        drive(1'b1, 1'b1, a, a, d, d);
        if (a != 5'd0) exp_sh[a] = d;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_fatal"}, {31'd0, fatal}, 32'd0);
        chk({tag, "_req"}, {30'd0, dbg_req}, 32'd0);
        chk({tag, "_halt"}, {31'd0, dbg_halt}, 32'd0);
        chk({tag, "_resume"}, {31'd0, dbg_resume}, 32'd0);
        chk({tag, "_we"}, {31'd0, dbg_we}, 32'd0);
        chk({tag, "_addr"}, {17'd0, dbg_addr}, 32'd0);
        chk({tag, "_wdata"}, dbg_wdata, 32'd0);
        chk({tag, "_cnt"}, {24'd0, rcnt}, 32'd0);
    endtask

    // Plays both cores' debug ports: core 1 grants `stagger` cycles into each word.
    task automatic collect(input int stagger, output int words, output int resume_at, output bit saw_400);
        int          age;
        logic [1:0]  tg, gg, ereq;
        logic [14:0] wa, ea;
        logic [31:0] wd, ed;
        words = 0; resume_at = -1; saw_400 = 1'b0; age = 0; tg = 2'b00; wa = '0; wd = '0;
        for (int c = 1; c <= 600; c++) begin
            step();
            if (dbg_resume) begin
                resume_at = c;
                break;
            end
            if (dbg_we) begin
                if (dbg_addr == 15'h400) saw_400 = 1'b1;
                ereq = ~tg;
                chk("req_pattern", {30'd0, dbg_req}, {30'd0, ereq});
                if (age == 0) begin
                    wa = dbg_addr; wd = dbg_wdata;
                end else begin
                    chk("addr_stable", {17'd0, dbg_addr}, {17'd0, wa});
                    chk("data_stable", dbg_wdata, wd);
                end
                gg[1] = dbg_req[1] & (age >= stagger);
                gg[0] = (stagger > 0) ? 1'b1 : dbg_req[0];
                gnt = gg;
                if ((tg | (dbg_req & gg)) == 2'b11) begin
                    if (words < 31) begin
                        ea = 15'h400 + 15'(4 * (words + 1));
                        ed = exp_sh[words + 1];
                    end else begin
                        ea = 15'h2000;
                        ed = exp_pc;
                    end
                    chk("word_addr", {17'd0, dbg_addr}, {17'd0, ea});
                    chk("word_data", dbg_wdata, ed);
                    words++; age = 0; tg = 2'b00;
                end else begin
                    tg = tg | (dbg_req & gg);
                    age++;
                end
            end else begin
                gnt = 2'b00;
                chk("req_idle", {30'd0, dbg_req}, 32'd0);
            end
        end
        gnt = 2'b00;
    endtask

    int  words, resume_at;
    bit  saw_400, found;

    initial begin
        rst_n = 1'b0; we_a = 0; we_b = 0; addr_a = 0; addr_b = 0; data_a = 0; data_b = 0;
        pc = 0; halted = 2'b00; gnt = 2'b00;
        for (int i = 0; i < 32; i++) exp_sh[i] = 32'd0;
        exp_pc = 32'd0;
        #3;
        check_zero("reset");
        @(posedge clk); #3 rst_n = 1'b1;
        step();
        check_zero("post_reset");

        // Data mismatch with pre-loaded shadow; x31 written the cycle before the mismatch.
        pc = 32'h80; halted = 2'b11;
        write_agree(5'd5, 32'h11);
        write_agree(5'd31, 32'hDEADBEEF);
        pc = 32'h84; exp_pc = 32'h80;
        drive(1'b1, 1'b1, 5'd7, 5'd7, 32'h1, 32'h2);
        chk("t1_halt", {31'd0, dbg_halt}, 32'd1);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_req_in_halt", {30'd0, dbg_req}, 32'd0);
        collect(0, words, resume_at, saw_400);
        chk("t1_words", words, 32);
        chk("t1_resume_at", resume_at, 34);
        step();
        chk("t1_cnt", {24'd0, rcnt}, 32'd1);
        chk("t1_idle", {31'd0, busy}, 32'd0);
        chk("t1_resume_once", {31'd0, dbg_resume}, 32'd0);

        // Enable mismatch after a dropped write to x0.
        pc = 32'h100;
        write_agree(5'd0, 32'h55);
        pc = 32'h104; exp_pc = 32'h100;
        drive(1'b1, 1'b0, 5'd9, 5'd9, 32'h7, 32'h7);
        chk("t2_halt", {31'd0, dbg_halt}, 32'd1);
        collect(0, words, resume_at, saw_400);
        chk("t2_words", words, 32);
        chk("t2_no_x0", {31'd0, saw_400}, 32'd0);
        step();
        chk("t2_cnt", {24'd0, rcnt}, 32'd2);

        // Address mismatch, core 1 grants three cycles late on every word.
        pc = 32'h180; step();
        pc = 32'h184; exp_pc = 32'h180;
        drive(1'b1, 1'b1, 5'd3, 5'd4, 32'h9, 32'h9);
        chk("t3_halt", {31'd0, dbg_halt}, 32'd1);
        collect(3, words, resume_at, saw_400);
        chk("t3_words", words, 32);
        chk("t3_resume_at", resume_at, 130);
        step();
        chk("t3_cnt", {24'd0, rcnt}, 32'd3);

        // Asynchronous reset while stalled on x10.
        drive(1'b1, 1'b1, 5'd2, 5'd2, 32'h1, 32'h3);
        found = 1'b0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (dbg_we && dbg_addr == 15'h428) begin
                found = 1'b1;
                break;
            end
            gnt = dbg_req;
        end
        gnt = 2'b00;
        chk("t4_reached_x10", {31'd0, found}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_zero("t4_async");
        @(posedge clk); #3 rst_n = 1'b1;
        for (int i = 0; i < 32; i++) exp_sh[i] = 32'd0;
        pc = 32'h200; step();
        check_zero("t4_released");
        pc = 32'h204; exp_pc = 32'h200;
        drive(1'b1, 1'b1, 5'd6, 5'd6, 32'h4, 32'h5);
        chk("t4_halt", {31'd0, dbg_halt}, 32'd1);
        collect(0, words, resume_at, saw_400);
        chk("t4_words", words, 32);
        chk("t4_resume_at", resume_at, 34);

        // Halt timeout with one core never halting.
        step();
        halted = 2'b01;
        drive(1'b0, 1'b1, 5'd1, 5'd1, 32'h0, 32'h0);
        chk("t5_halt", {31'd0, dbg_halt}, 32'd1);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("t5_not_yet_fatal", {31'd0, fatal}, 32'd0);
            chk("t5_no_req_wait", {30'd0, dbg_req}, 32'd0);
        end
        step();
        chk("t5_fatal", {31'd0, fatal}, 32'd1);
        chk("t5_busy", {31'd0, busy}, 32'd1);
        halted = 2'b11;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 5'd1, 5'd1, 32'h0, 32'h0);
            chk("t5_fatal_held", {31'd0, fatal}, 32'd1);
            chk("t5_no_req_fail", {30'd0, dbg_req}, 32'd0);
        end
        rst_n = 1'b0;
        #1;
        check_zero("t5_reset");
        @(posedge clk); #3 rst_n = 1'b1;

        // 256 recoveries: counter saturates.
        pc = 32'h300; exp_pc = 32'h300; step();
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 1'b1, 5'd8, 5'd8, 32'h1, 32'h0);
            collect(0, words, resume_at, saw_400);
            step();
            if (i == 0) chk("t6_cnt_first", {24'd0, rcnt}, 32'd1);
            if (i == 253) chk("t6_cnt_254", {24'd0, rcnt}, 32'd254);
            if (i == 254) chk("t6_cnt_255", {24'd0, rcnt}, 32'd255);
        end
        chk("t6_words_last", words, 32);
        chk("t6_cnt_sat", {24'd0, rcnt}, 32'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
